cla_adder_pipe: RTL and testbench
=================================

// Module: cla_adder_pipe
// PURPOSE
//  Parametrised two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
//  Operands are split into 4-bit lookahead groups; each group yields group generate G and propagate P.
//  A second lookahead level across groups forms every group carry-in.
//  Sits in the datapath as a streaming arithmetic unit: throughput 1 op/cycle, latency 2 cycles.
// PARAMETERS
//  WIDTH    16  operand/sum width in bits; must be a multiple of 4 and >= 4
//  NGROUPS  WIDTH/4  derived localparam, number of 4-bit lookahead groups
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in; ignored when sub=1
//  sub        in   1      0: A+B+cin; 1: A-B, computed as A+~B+1
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB; for sub, 1 = no borrow
//  ovf        out  1      signed overflow = carry into MSB XOR cout
// BEHAVIOUR
//  Reset (async, immediate): s1_valid=0, s2_valid=0; out_valid=0, sum=0, cout=0, ovf=0.
//   Any in-flight beats are discarded, with no partial result emitted.
//  Handshake: a beat transfers on a cycle where valid && ready are both high.
//   Stage enables: s2_en = !s2_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en.
//   in_ready is combinational from out_ready and the stage valid bits; it never depends on in_valid.
//   While out_valid=1 and out_ready=0, sum/cout/ovf/out_valid hold stable.
//   With out_ready held high, one result per cycle, exactly 2 cycles after acceptance.
//   With out_ready held low, at most 2 beats are buffered. in_ready then drops; there is no loss or duplication.
//  Stage 1, on a transfer with s1_en:
//   Register bit p=a^b', g=a&b', with b'=sub?~b:b.
//   Register c0=sub?1:cin.
//   Register per-group G,P, 4-bit lookahead:
//    G=g3|p3g2|p3p2g1|p3p2p1g0; P=p3p2p1p0.
//   s1_valid <= in_valid.
//  Stage 2, with s2_en:
//   Group carries: C[0]=c0; C[k+1]=G[k]|(P[k]&C[k]), expanded in lookahead form per group.
//   In-group carries: c1=g0|p0c; c2=g1|p1g0|p1p0c; c3=g2|p2g1|p2p1g0|p2p1p0c.
//   sum[i]=p[i]^carry[i]; cout=C[NGROUPS]; ovf=carry[WIDTH-1]^cout.
//   s2_valid <= s1_valid; out_valid = s2_valid.
//  When stage 1 is empty and s1_en=1, its data regs may load don't-care values; they are never observed.
//  Arithmetic: modulo 2^WIDTH; the result is bit-exact to {cout,sum} = a + b' + c0.
//  Simultaneous: a new beat is accepted in the same cycle that stage 2 drains; full throughput with out_ready=1.
// TESTING
//  1 Reset assert mid-stream with 2 beats in flight -> next cycle out_valid=0, sum=0; no stale beat after release.
//  2 WIDTH=16, a=FFFF, b=0001, cin=0, sub=0 -> 2 cycles later sum=0000, cout=1, ovf=0.
//  3 a=7FFF, b=0001, cin=0 -> sum=8000, cout=0, ovf=1; a=0005, b=0007, sub=1 -> sum=FFFE, cout=0, ovf=0.
//  4 Stream 5 beats, out_ready=0 for cycles 2-4 -> in_ready low after 2 accepted; all 5 results emerge in order, held stable while stalled.
//  5 Full-carry chain: a=FFFF, b=0000, cin=1 -> sum=0000, cout=1; repeat for WIDTH=4, 8, 32.
//  6 10k random beats, random in_valid/out_ready, random sub/cin -> every result matches the a+b'+c0 model, in order.

Source files
------------

// File: rtl/cla_adder_pipe_if.sv
// Streaming operand/result bus for the pipelined CLA adder/subtractor.
// master drives operands and accepts results; slave is the arithmetic unit.
interface cla_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with 4-bit groups; latency 2, 1 op/cycle.
// Backpressure: each stage advances when empty or when the next one drains; in_ready ignores in_valid.
module cla_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    cla_adder_pipe_if.slave    bus
);
    localparam int NGROUPS = WIDTH / 4;

    // Group generate/propagate: {G, P}
    function automatic logic [1:0] group_gp(input logic [3:0] p, input logic [3:0] g);
        logic gg;
        logic gp;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp = p[3] & p[2] & p[1] & p[0];
        return {gg, gp};
    endfunction

    // Carry into each bit of a group, given the group carry-in.
    function automatic logic [3:0] group_bit_carries(input logic [3:0] p, input logic [3:0] g,
                                                     input logic c);
        logic [3:0] cc;
        cc[0] = c;
        cc[1] = g[0] | (p[0] & c);
        cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        return cc;
    endfunction

    // Second lookahead level: each group carry as a flat sum of products, not a ripple.
    function automatic logic [NGROUPS:0] group_carries(input logic [NGROUPS-1:0] gg,
                                                       input logic [NGROUPS-1:0] gp,
                                                       input logic c0);
        logic [NGROUPS:0] cg;
        logic             term_p;
        cg[0] = c0;
        for (int k = 0; k < NGROUPS; k++) begin
            cg[k+1] = gg[k];
            term_p  = gp[k];
            for (int j = k - 1; j >= 0; j--) begin
                cg[k+1] = cg[k+1] | (term_p & gg[j]);
                term_p  = term_p & gp[j];
            end
            cg[k+1] = cg[k+1] | (term_p & c0);
        end
        return cg;
    endfunction

    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]   g_q, g_d;
    logic               c0_q, c0_d;
    logic [NGROUPS-1:0] gg_q, gg_d;
    logic [NGROUPS-1:0] gp_q, gp_d;

    logic               s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               s1_en;
    logic               s2_en;
    logic [WIDTH-1:0]   b_eff;
    logic [NGROUPS:0]   grp_c;
    logic [WIDTH-1:0]   carry;

    always_comb begin
        s2_en = !s2_valid_q || bus.out_ready;
        s1_en = !s1_valid_q || s2_en;
    end

    assign bus.in_ready  = s1_en;
    assign bus.out_valid = s2_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    always_comb begin
        b_eff      = bus.sub ? ~bus.b : bus.b;
        s1_valid_d = s1_valid_q;
        p_d        = p_q;
        g_d        = g_q;
        c0_d       = c0_q;
        gg_d       = gg_q;
        gp_d       = gp_q;
        if (s1_en) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                p_d  = bus.a ^ b_eff;
                g_d  = bus.a & b_eff;
                c0_d = bus.sub | bus.cin;
                for (int k = 0; k < NGROUPS; k++) begin
                    {gg_d[k], gp_d[k]} = group_gp(p_d[4*k +: 4], g_d[4*k +: 4]);
                end
            end
        end
    end

    always_comb begin
        grp_c = group_carries(gg_q, gp_q, c0_q);
        carry = '0;
        for (int k = 0; k < NGROUPS; k++) begin
            carry[4*k +: 4] = group_bit_carries(p_q[4*k +: 4], g_q[4*k +: 4], grp_c[k]);
        end
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            // Result regs only load real beats so idle outputs stay quiet.
            if (s1_valid_q) begin
                sum_d  = p_q ^ carry;
                cout_d = grp_c[NGROUPS];
                ovf_d  = carry[WIDTH-1] ^ grp_c[NGROUPS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            c0_q       <= 1'b0;
            gg_q       <= '0;
            gp_q       <= '0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            p_q        <= p_d;
            g_q        <= g_d;
            c0_q       <= c0_d;
            gg_q       <= gg_d;
            gp_q       <= gp_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: vector table, stall/reset sequences, width sweep and random stream.
module tb_cla_adder_pipe;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_adder_pipe_if #(.WIDTH(16)) bus ();
    cla_adder_pipe_if #(.WIDTH(4))  w4_if ();
    cla_adder_pipe_if #(.WIDTH(8))  w8_if ();
    cla_adder_pipe_if #(.WIDTH(32)) w32_if ();

    cla_adder_pipe #(.WIDTH(16)) dut     (.clk(clk), .rst(rst), .bus(bus));
    cla_adder_pipe #(.WIDTH(4))  dut_w4  (.clk(clk), .rst(rst), .bus(w4_if));
    cla_adder_pipe #(.WIDTH(8))  dut_w8  (.clk(clk), .rst(rst), .bus(w8_if));
    cla_adder_pipe #(.WIDTH(32)) dut_w32 (.clk(clk), .rst(rst), .bus(w32_if));

    res_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    res_t held;
    bit   held_vld = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W:0]   t;
        logic [W-1:0] bb;
        res_t         r;
        bb     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (a[W-1] ^ bb[W-1] ^ t[W-1]) ^ t[W];
        return r;
    endfunction

    function automatic res_t cur_model();
        return model(bus.a, bus.b, bus.cin, bus.sub);
    endfunction

    // One cycle: settle after the falling edge, account handshakes, then cross the rising edge.
    task automatic tick(input res_t e, output bit acc);
        res_t got;
        #1;
        got = {bus.sum, bus.cout, bus.ovf};
        if (held_vld) begin
            check("hold_valid", 64'(bus.out_valid), 64'(1));
            check("hold_data", 64'(got), 64'(held));
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) exp_q.push_back(e);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %0h, expected no beat", got);
            end else begin
                check("result", 64'(got), 64'(exp_q.pop_front()));
            end
        end
        held_vld = bus.out_valid && !bus.out_ready;
        held     = got;
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            tick('0, acc);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        bus.sub = sub;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        bit   acc;
        int   bi;
        int   acc_n;
        logic [W-1:0] sa[5];
        logic [W-1:0] sb[5];

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[7]  = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[9]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[10] = '{16'h000A, 16'h0003, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b0};
        vecs[11] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        set_op('0, '0, 1'b0, 1'b0);
        w4_if.in_valid = 1'b0;  w4_if.out_ready = 1'b1;  w4_if.a = '0;  w4_if.b = '0;  w4_if.cin = 1'b0;  w4_if.sub = 1'b0;
        w8_if.in_valid = 1'b0;  w8_if.out_ready = 1'b1;  w8_if.a = '0;  w8_if.b = '0;  w8_if.cin = 1'b0;  w8_if.sub = 1'b0;
        w32_if.in_valid = 1'b0; w32_if.out_ready = 1'b1; w32_if.a = '0; w32_if.b = '0; w32_if.cin = 1'b0; w32_if.sub = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_sum", 64'(bus.sum), 64'(0));
        check("reset_cout_ovf", 64'({bus.cout, bus.ovf}), 64'(0));
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // Vector table at full throughput.
        for (int i = 0; i < 12; i++) begin
            set_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            bus.in_valid = 1'b1;
            tick({vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf}, acc);
            check("table_accept", 64'(acc), 64'(1));
        end
        drain();

        // Latency: result visible exactly two edges after acceptance.
        set_op(16'h0102, 16'h0304, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        tick({16'h0406, 1'b0, 1'b0}, acc);
        bus.in_valid = 1'b0;
        #1;
        check("latency_1cyc_vld", 64'(bus.out_valid), 64'(0));
        tick('0, acc);
        #1;
        check("latency_2cyc_vld", 64'(bus.out_valid), 64'(1));
        drain();

        // Five beats, downstream stalled on cycles 2..4.
        for (int k = 0; k < 5; k++) begin
            sa[k] = 16'(16'h1111 * (k + 1));
            sb[k] = 16'(16'h0F0F + k);
        end
        bi = 0;
        for (int cyc = 0; cyc < 40 && bi < 5; cyc++) begin
            bus.in_valid  = 1'b1;
            set_op(sa[bi], sb[bi], 1'(bi), 1'(bi == 3));
            bus.out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (cyc >= 2 && cyc <= 4) check("stall_in_ready", 64'(bus.in_ready), 64'(0));
            if (cyc == 4) check("stall_accepted", 64'(bi), 64'(2));
            tick(cur_model(), acc);
            if (acc) bi++;
        end
        check("stall_all_accepted", 64'(bi), 64'(5));
        drain();

        // Asynchronous reset with two beats in flight.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            set_op(16'h4000 + 16'(k), 16'h0100, 1'b1, 1'b0);
            tick(cur_model(), acc);
        end
        bus.in_valid = 1'b0;
        #1;
        check("pre_reset_vld", 64'(bus.out_valid), 64'(1));
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_vld", 64'(bus.out_valid), 64'(0));
        check("async_reset_sum", 64'({bus.sum, bus.cout, bus.ovf}), 64'(0));
        exp_q.delete();
        held_vld = 1'b0;
        @(negedge clk);
        #1;
        check("reset_next_cycle_vld", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("post_reset_no_stale", 64'(bus.out_valid), 64'(0));
            tick('0, acc);
        end

        // Full carry chain and borrow for other widths.
        for (int c = 0; c < 2; c++) begin
            w4_if.a  = c == 0 ? 4'hF : 4'h1;          w4_if.b  = c == 0 ? 4'h0 : 4'h2;
            w8_if.a  = c == 0 ? 8'hFF : 8'h01;        w8_if.b  = c == 0 ? 8'h00 : 8'h02;
            w32_if.a = c == 0 ? 32'hFFFF_FFFF : 32'h1; w32_if.b = c == 0 ? 32'h0 : 32'h2;
            w4_if.cin = 1'b1; w8_if.cin = 1'b1; w32_if.cin = 1'b1;
            w4_if.sub = 1'(c); w8_if.sub = 1'(c); w32_if.sub = 1'(c);
            w4_if.in_valid = 1'b1; w8_if.in_valid = 1'b1; w32_if.in_valid = 1'b1;
            @(negedge clk);
            w4_if.in_valid = 1'b0; w8_if.in_valid = 1'b0; w32_if.in_valid = 1'b0;
            @(negedge clk);
            #1;
            check("w4_result",  64'({w4_if.out_valid, w4_if.sum, w4_if.cout}),
                  c == 0 ? 64'({1'b1, 4'h0, 1'b1}) : 64'({1'b1, 4'hF, 1'b0}));
            check("w8_result",  64'({w8_if.out_valid, w8_if.sum, w8_if.cout}),
                  c == 0 ? 64'({1'b1, 8'h00, 1'b1}) : 64'({1'b1, 8'hFF, 1'b0}));
            check("w32_result", 64'({w32_if.out_valid, w32_if.sum, w32_if.cout}),
                  c == 0 ? 64'({1'b1, 32'h0, 1'b1}) : 64'({1'b1, 32'hFFFF_FFFF, 1'b0}));
            @(negedge clk);
        end

        // Random stream with random valid/ready.
        acc_n = 0;
        for (int cyc = 0; cyc < 60000 && acc_n < 10000; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            set_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 15) == 0) bus.a = 16'hFFFF;
            tick(cur_model(), acc);
            if (acc) acc_n++;
        end
        check("random_accepted", 64'(acc_n), 64'(10000));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
